mem_access_unit: RTL and testbench

- Load/store initiator between the CPU execute stage and the word-addressed data RAM.
- The RAM has a combinational read, a synchronous write, and word-only access; it ignores address bits [1:0].
- Converts RV32I byte, halfword and word loads/stores into word transactions: sign/zero-extends loads, and performs read-modify-write for sub-word stores.
- Flags misaligned or illegal accesses and issues no memory write for them. Sits alongside the RAM in DATA_MEMORY.

---
 rtl/mem_access_unit.sv | 139 +++++++++++++
 tb/tb_mem_access_unit.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Load/store initiator: turns RV32I byte/half/word accesses into word-wide RAM
// transactions, with sign/zero extension on loads and read-modify-write on sub-word stores.
module mem_access_unit #(
    parameter int DATA_WIDTH   = 32,
    parameter int FUNCT3_WIDTH = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [FUNCT3_WIDTH-1:0] req_funct3,
    input  logic [DATA_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    output logic                    resp_valid,
    output logic                    resp_err,
    output logic [DATA_WIDTH-1:0]   resp_rdata,
    output logic                    mem_we,
    output logic [DATA_WIDTH-1:0]   mem_a,
    output logic [DATA_WIDTH-1:0]   mem_wd,
    input  logic [DATA_WIDTH-1:0]   mem_rd
);

    localparam logic [FUNCT3_WIDTH-1:0] F3_B  = 3'b000;
    localparam logic [FUNCT3_WIDTH-1:0] F3_H  = 3'b001;
    localparam logic [FUNCT3_WIDTH-1:0] F3_W  = 3'b010;
    localparam logic [FUNCT3_WIDTH-1:0] F3_BU = 3'b100;
    localparam logic [FUNCT3_WIDTH-1:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [DATA_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [DATA_WIDTH-1:0]   r_word;
    logic [FUNCT3_WIDTH-1:0] r_funct3;
    logic                    r_we;
    logic                    r_err;

    logic                    w_accept;
    logic                    w_req_err;
    logic [7:0]              w_byte;
    logic [15:0]             w_half;
    logic [DATA_WIDTH-1:0]   w_load;
    logic [DATA_WIDTH-1:0]   w_merged;

    assign req_ready = (r_state == IDLE) && !rst;
    assign w_accept  = req_valid && req_ready;

    // Misalignment and illegal-encoding detection on the incoming request
    always_comb begin
        w_req_err = 1'b1;
        case (req_funct3)
            F3_B:    w_req_err = 1'b0;
            F3_H:    w_req_err = req_addr[0];
            F3_W:    w_req_err = |req_addr[1:0];
            F3_BU:   w_req_err = req_we;
            F3_HU:   w_req_err = req_we || req_addr[0];
            default: w_req_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_word   <= '0;
            r_funct3 <= '0;
            r_we     <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_addr   <= req_addr;
                r_wdata  <= req_wdata;
                r_funct3 <= req_funct3;
                r_we     <= req_we;
                r_err    <= w_req_err;
            end
            if (r_state == READ) begin
                r_word <= mem_rd;
            end
        end
    end

    // Word stores skip READ; sub-word stores need the old word before writing
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_req_err)                        w_next = DONE;
                    else if (req_we && req_funct3 == F3_W) w_next = WRITE;
                    else                                  w_next = READ;
                end
            end
            READ:    w_next = r_we ? WRITE : DONE;
            WRITE:   w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    assign w_byte = r_word[{r_addr[1:0], 3'b000} +: 8];
    assign w_half = r_word[{r_addr[1], 4'b0000} +: 16];

    always_comb begin
        w_load = '0;
        case (r_funct3)
            F3_B:    w_load = {{(DATA_WIDTH-8){w_byte[7]}}, w_byte};
            F3_H:    w_load = {{(DATA_WIDTH-16){w_half[15]}}, w_half};
            F3_W:    w_load = r_word;
            F3_BU:   w_load = {{(DATA_WIDTH-8){1'b0}}, w_byte};
            F3_HU:   w_load = {{(DATA_WIDTH-16){1'b0}}, w_half};
            default: w_load = '0;
        endcase
    end

    always_comb begin
        w_merged = r_word;
        case (r_funct3)
            F3_B:    w_merged[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
            F3_H:    w_merged[{r_addr[1], 4'b0000} +: 16] = r_wdata[15:0];
            F3_W:    w_merged = r_wdata;
            default: w_merged = r_word;
        endcase
    end

    // Gating with rst guarantees no write or response on an aborting edge
    assign mem_we     = (r_state == WRITE) && !rst;
    assign mem_a      = {r_addr[DATA_WIDTH-1:2], 2'b00};
    assign mem_wd     = (r_state == WRITE) ? w_merged : '0;
    assign resp_valid = (r_state == DONE) && !rst;
    assign resp_err   = resp_valid && r_err;
    assign resp_rdata = (resp_valid && !r_we && !r_err) ? w_load : '0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed accesses against a behavioural word RAM,
// with a monitor that checks responses and RAM writes against queued expectations.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic        mem_we;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          lat;
    } expT;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wrT;

    expT expQ[$];
    int  acceptQ[$];
    wrT  wrQ[$];

    int errors = 0;
    int checks = 0;
    int cycle = 0;
    int lastRespCycle = 0;
    int lastAccept = 0;
    int firstRespCycle = 0;

    logic [31:0] ram [64];
    logic        bdWe = 1'b0;
    logic        bdClear = 1'b1;
    logic [5:0]  bdIdx = '0;
    logic [31:0] bdData = '0;

    mem_access_unit #(.DATA_WIDTH(32), .FUNCT3_WIDTH(3)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
        .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Combinational-read, synchronous-write RAM with a backdoor for preloading
    assign mem_rd = ram[mem_a[7:2]];
    always @(posedge clk) begin
        if (bdClear) begin
            for (int i = 0; i < 64; i++) ram[i] <= '0;
        end else if (mem_we) begin
            ram[mem_a[7:2]] <= mem_wd;
        end else if (bdWe) begin
            ram[bdIdx] <= bdData;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", name, actual, expected, cycle);
        end
    endtask

    task automatic monitor();
        expT e;
        wrT  w;
        int  a;
        forever begin
            @(negedge clk);
            #1;
            if (resp_valid) begin
                lastRespCycle = cycle;
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpectedResp: got resp_valid=1 expected none at cycle %0d", cycle);
                end else begin
                    e = expQ.pop_front();
                    a = acceptQ.pop_front();
                    checkOutput("respErr", {31'b0, resp_err}, {31'b0, e.err});
                    checkOutput("respRdata", resp_rdata, e.rdata);
                    checkOutput("respLatency", 32'(cycle - a), 32'(e.lat));
                end
            end
            if (mem_we) begin
                if (wrQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpectedWrite: got mem_we=1 addr 0x%08h data 0x%08h expected none", mem_a, mem_wd);
                end else begin
                    w = wrQ.pop_front();
                    checkOutput("memAddr", mem_a, w.addr);
                    checkOutput("memWdata", mem_wd, w.data);
                end
            end
        end
    endtask

    // Present a request, hold it until accepted, and queue what the DUT must answer
    task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic expErr, input logic [31:0] expRdata,
                                 input int expLat, input bit expectResp, input bit expectWrite,
                                 input logic [31:0] wrAddr, input logic [31:0] wrData);
        int waitCycles = 0;
        expT e;
        wrT  w;
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        while (!req_ready && waitCycles < 50) begin
            @(negedge clk);
            waitCycles++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL acceptTimeout: got req_ready=0 expected 1 within 50 cycles");
            req_valid = 1'b0;
            return;
        end
        lastAccept = cycle;
        if (expectResp) begin
            e.err = expErr; e.rdata = expRdata; e.lat = expLat;
            expQ.push_back(e);
            acceptQ.push_back(cycle);
        end
        if (expectWrite) begin
            w.addr = wrAddr; w.data = wrData;
            wrQ.push_back(w);
        end
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((expQ.size() != 0 || wrQ.size() != 0) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (expQ.size() != 0 || wrQ.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drainTimeout: got %0d responses and %0d writes pending expected 0", expQ.size(), wrQ.size());
            expQ.delete(); acceptQ.delete(); wrQ.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic backdoorWrite(input logic [5:0] idx, input logic [31:0] d);
        bdIdx = idx; bdData = d; bdWe = 1'b1;
        @(negedge clk);
        bdWe = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0;
        req_funct3 = '0; req_addr = '0; req_wdata = '0;
        fork
            monitor();
        join_none
        repeat (2) @(negedge clk);
        bdClear = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("rstReady", {31'b0, req_ready}, 32'h0);
        checkOutput("rstRespValid", {31'b0, resp_valid}, 32'h0);
        checkOutput("rstRespRdata", resp_rdata, 32'h0);
        checkOutput("rstMemWe", {31'b0, mem_we}, 32'h0);
        checkOutput("rstMemA", mem_a, 32'h0);
        checkOutput("rstMemWd", mem_wd, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("readyAfterRst", {31'b0, req_ready}, 32'h1);
        @(negedge clk);

        // Sub-word store into a zero word, then read it back
        applyStimulus(1, 3'b000, 32'h11, 32'h77, 0, 32'h0, 3, 1, 1, 32'h10, 32'h0000_7700);
        applyStimulus(0, 3'b010, 32'h10, 32'h0, 0, 32'h0000_7700, 2, 1, 0, 32'h0, 32'h0);
        drain();

        backdoorWrite(6'd4, 32'hAABB_CCDD);
        applyStimulus(0, 3'b000, 32'h13, 32'h0, 0, 32'hFFFF_FFAA, 2, 1, 0, 32'h0, 32'h0);
        applyStimulus(0, 3'b100, 32'h13, 32'h0, 0, 32'h0000_00AA, 2, 1, 0, 32'h0, 32'h0);
        applyStimulus(0, 3'b001, 32'h10, 32'h0, 0, 32'hFFFF_CCDD, 2, 1, 0, 32'h0, 32'h0);
        applyStimulus(0, 3'b101, 32'h12, 32'h0, 0, 32'h0000_AABB, 2, 1, 0, 32'h0, 32'h0);
        applyStimulus(0, 3'b010, 32'h10, 32'h0, 0, 32'hAABB_CCDD, 2, 1, 0, 32'h0, 32'h0);
        applyStimulus(0, 3'b000, 32'h10, 32'h0, 0, 32'hFFFF_FFDD, 2, 1, 0, 32'h0, 32'h0);
        applyStimulus(0, 3'b100, 32'h11, 32'h0, 0, 32'h0000_00CC, 2, 1, 0, 32'h0, 32'h0);
        applyStimulus(0, 3'b001, 32'h12, 32'h0, 0, 32'hFFFF_AABB, 2, 1, 0, 32'h0, 32'h0);
        drain();

        applyStimulus(1, 3'b001, 32'h12, 32'h1234_BEEF, 0, 32'h0, 3, 1, 1, 32'h10, 32'hBEEF_CCDD);
        applyStimulus(0, 3'b010, 32'h10, 32'h0, 0, 32'hBEEF_CCDD, 2, 1, 0, 32'h0, 32'h0);
        applyStimulus(1, 3'b010, 32'h14, 32'hDEAD_BEEF, 0, 32'h0, 2, 1, 1, 32'h14, 32'hDEAD_BEEF);
        applyStimulus(0, 3'b010, 32'h14, 32'h0, 0, 32'hDEAD_BEEF, 2, 1, 0, 32'h0, 32'h0);
        drain();

        // Faulting accesses: one-cycle error response, no RAM traffic
        applyStimulus(0, 3'b010, 32'h11, 32'h0, 1, 32'h0, 1, 1, 0, 32'h0, 32'h0);
        applyStimulus(0, 3'b001, 32'h03, 32'h0, 1, 32'h0, 1, 1, 0, 32'h0, 32'h0);
        applyStimulus(1, 3'b010, 32'h06, 32'h5555_5555, 1, 32'h0, 1, 1, 0, 32'h0, 32'h0);
        applyStimulus(0, 3'b011, 32'h00, 32'h0, 1, 32'h0, 1, 1, 0, 32'h0, 32'h0);
        applyStimulus(1, 3'b100, 32'h10, 32'h66, 1, 32'h0, 1, 1, 0, 32'h0, 32'h0);
        applyStimulus(0, 3'b101, 32'h11, 32'h0, 1, 32'h0, 1, 1, 0, 32'h0, 32'h0);
        drain();
        checkOutput("ramWord1", ram[1], 32'h0);
        checkOutput("ramWord4", ram[4], 32'hBEEF_CCDD);
        checkOutput("ramWord5", ram[5], 32'hDEAD_BEEF);

        // Abort an SB in its WRITE cycle
        applyStimulus(1, 3'b000, 32'h10, 32'h55, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("abortMemWe", {31'b0, mem_we}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("abortReady", {31'b0, req_ready}, 32'h1);
        repeat (4) @(negedge clk);
        checkOutput("abortRamWord4", ram[4], 32'hBEEF_CCDD);

        // Second LW held while the first is in flight
        applyStimulus(0, 3'b010, 32'h10, 32'h0, 0, 32'hBEEF_CCDD, 2, 1, 0, 32'h0, 32'h0);
        applyStimulus(0, 3'b010, 32'h14, 32'h0, 0, 32'hDEAD_BEEF, 2, 1, 0, 32'h0, 32'h0);
        firstRespCycle = lastRespCycle;
        checkOutput("heldAcceptCycle", 32'(lastAccept), 32'(firstRespCycle + 1));
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
